// File: rtl/operand_bank_loader_pkg.sv
// Constants and types shared by the operand bank loader, its memories and the
// systolic controller.
package operand_bank_loader_pkg;

  localparam int DATA_W           = 32;
  localparam int ADDR_W           = 3;
  localparam int SEL_W            = 3;
  localparam int BANK_W           = 4;
  localparam int NUM_BANKS        = 8;
  localparam int READ_LATENCY     = 2;
  localparam int BANK_ENTRIES     = 64;
  localparam int MEM_DEPTH        = 1 << ADDR_W;
  localparam int ENTRIES_PER_BANK = 1 << SEL_W;
  localparam int CNT_W            = 7;

  // Stage-1 capture of a controller read request.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rom_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [BANK_W-1:0] bank;
    logic [SEL_W-1:0]  sel;
  } req_t;

endpackage

// File: rtl/operand_mem.sv
// 8-word operand memory: one host write port, one synchronous read port,
// read-before-write. Also exposes the raw array word for same-edge consumers.
module operand_mem
  import operand_bank_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the storage array carries no reset so it maps onto plain RAM/LUT cells;
  // only the read register below is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_word = mem_q[rd_addr];

  // NOTE: non-blocking assignment samples the pre-edge array, which is what
  // gives read-before-write against a same-edge host write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= rd_word;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/operand_bank_loader.sv
// Memory-side responder: 2-stage read pipeline into ROM/RAM operand memories,
// writing each returned pair into an 8x8 operand bank for the MAC array.
module operand_bank_loader
  import operand_bank_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] rom_address,
  input  logic [ADDR_W-1:0] ram_address,
  input  logic [BANK_W-1:0] bank_select_line,
  input  logic [SEL_W-1:0]  select_line,
  input  logic              init_we,
  input  logic              init_mem,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [SEL_W-1:0]  rd_bank,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] weight_out,
  output logic [DATA_W-1:0] act_out,
  output logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ram_data,
  output logic              data_valid,
  output logic [CNT_W-1:0]  fill_count,
  output logic              load_done,
  output logic              overrun
);

  req_t              s1_q, s1_d;
  logic              s2_fire, in_range, bank_we;
  logic [SEL_W-1:0]  bank_idx;
  logic [DATA_W-1:0] rom_word, ram_word;

  logic              data_valid_q, data_valid_d;
  logic [CNT_W-1:0]  fill_count_q, fill_count_d;
  logic              load_done_q, load_done_d;
  logic              overrun_q, overrun_d;

  logic [DATA_W-1:0] weight_bank_q [NUM_BANKS][ENTRIES_PER_BANK];
  logic [DATA_W-1:0] act_bank_q    [NUM_BANKS][ENTRIES_PER_BANK];

  operand_mem u_rom (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (init_we & ~init_mem),
    .wr_addr (init_addr),
    .wr_data (init_data),
    .rd_en   (s2_fire),
    .rd_addr (s1_q.rom_addr),
    .rd_word (rom_word),
    .rd_data (rom_data)
  );

  operand_mem u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (init_we & init_mem),
    .wr_addr (init_addr),
    .wr_data (init_data),
    .rd_en   (s2_fire),
    .rd_addr (s1_q.ram_addr),
    .rd_word (ram_word),
    .rd_data (ram_data)
  );

  assign s2_fire  = enable & s1_q.valid;
  assign in_range = s1_q.bank < BANK_W'(NUM_BANKS);
  assign bank_we  = s2_fire & in_range;
  assign bank_idx = s1_q.bank[SEL_W-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    s1_d         = s1_q;
    data_valid_d = data_valid_q;
    fill_count_d = fill_count_q;
    load_done_d  = load_done_q;
    overrun_d    = overrun_q;
    if (enable) begin
      s1_d.valid   = read_en;
      data_valid_d = s1_q.valid;
      load_done_d  = 1'b0;
      if (read_en) begin
        s1_d.rom_addr = rom_address;
        s1_d.ram_addr = ram_address;
        s1_d.bank     = bank_select_line;
        s1_d.sel      = select_line;
      end
      if (clear) begin
        fill_count_d = '0;
        overrun_d    = 1'b0;
      end else begin
        // Saturating count; the 63->64 step happens once per clear, so the pulse does too.
        if (bank_we && fill_count_q < CNT_W'(BANK_ENTRIES)) begin
          fill_count_d = fill_count_q + 1'b1;
          load_done_d  = (fill_count_q == CNT_W'(BANK_ENTRIES - 1));
        end
        if (s2_fire && !in_range) begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= '0;
      data_valid_q <= 1'b0;
      fill_count_q <= '0;
      load_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      data_valid_q <= data_valid_d;
      fill_count_q <= fill_count_d;
      load_done_q  <= load_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Bank write uses the unregistered memory words so the entry lands on the
  // same edge that raises data_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES_PER_BANK; e++) begin
          weight_bank_q[b][e] <= '0;
          act_bank_q[b][e]    <= '0;
        end
      end
    end else if (bank_we) begin
      weight_bank_q[bank_idx][s1_q.sel] <= rom_word;
      act_bank_q[bank_idx][s1_q.sel]    <= ram_word;
    end
  end

  assign weight_out = weight_bank_q[rd_bank][rd_sel];
  assign act_out    = act_bank_q[rd_bank][rd_sel];
  assign data_valid = data_valid_q;
  assign fill_count = fill_count_q;
  assign load_done  = load_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_operand_bank_loader.sv
// Directed bench for operand_bank_loader: latency, bank fill, overrun, stall,
// preload collision and mid-stream reset, with hand-computed expectations.
module tb_operand_bank_loader;
  import operand_bank_loader_pkg::*;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              clear;
  logic              read_en;
  logic [ADDR_W-1:0] rom_address;
  logic [ADDR_W-1:0] ram_address;
  logic [BANK_W-1:0] bank_select_line;
  logic [SEL_W-1:0]  select_line;
  logic              init_we;
  logic              init_mem;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic [SEL_W-1:0]  rd_bank;
  logic [SEL_W-1:0]  rd_sel;
  logic [DATA_W-1:0] weight_out;
  logic [DATA_W-1:0] act_out;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] ram_data;
  logic              data_valid;
  logic [CNT_W-1:0]  fill_count;
  logic              load_done;
  logic              overrun;

  int n_checks;
  int n_errors;

  operand_bank_loader dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .clear            (clear),
    .read_en          (read_en),
    .rom_address      (rom_address),
    .ram_address      (ram_address),
    .bank_select_line (bank_select_line),
    .select_line      (select_line),
    .init_we          (init_we),
    .init_mem         (init_mem),
    .init_addr        (init_addr),
    .init_data        (init_data),
    .rd_bank          (rd_bank),
    .rd_sel           (rd_sel),
    .weight_out       (weight_out),
    .act_out          (act_out),
    .rom_data         (rom_data),
    .ram_data         (ram_data),
    .data_valid       (data_valid),
    .fill_count       (fill_count),
    .load_done        (load_done),
    .overrun          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input int ra, input int wa, input int b, input int s);
    read_en          = 1'b1;
    rom_address      = ADDR_W'(ra);
    ram_address      = ADDR_W'(wa);
    bank_select_line = BANK_W'(b);
    select_line      = SEL_W'(s);
  endtask

  task automatic look(input int b, input int s);
    rd_bank = SEL_W'(b);
    rd_sel  = SEL_W'(s);
    #1;
  endtask

  task automatic preload(input logic m, input int a, input logic [DATA_W-1:0] d);
    init_we   = 1'b1;
    init_mem  = m;
    init_addr = ADDR_W'(a);
    init_data = d;
    step();
    init_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv_cnt, ld_cnt, ld_at, ld_again, dv_seen;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; enable = 1'b0; clear = 1'b0; read_en = 1'b0;
    rom_address = '0; ram_address = '0; bank_select_line = '0; select_line = '0;
    init_we = 1'b0; init_mem = 1'b0; init_addr = '0; init_data = '0;
    rd_bank = '0; rd_sel = '0;

    step(); step();
    check("rst_rom_data", rom_data, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_fill_count", fill_count, 0);
    check("rst_load_done", load_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_weight_out", weight_out, 0);
    reset  = 1'b0;
    enable = 1'b1;

    for (int i = 0; i < 8; i++) preload(1'b0, i, 32'h100 + i);
    for (int i = 0; i < 8; i++) preload(1'b1, i, 32'h200 + i);

    // Single request: addr 3 -> bank 2, entry 5.
    req(3, 3, 2, 5);
    look(2, 5);
    step();
    read_en = 1'b0;
    check("single_dv_t1", data_valid, 0);
    check("single_bank_before", weight_out, 0);
    step();
    check("single_dv_t2", data_valid, 1);
    check("single_rom_data", rom_data, 32'h103);
    check("single_ram_data", ram_data, 32'h203);
    check("single_weight_out", weight_out, 32'h103);
    check("single_act_out", act_out, 32'h203);
    check("single_fill", fill_count, 1);
    step();
    check("single_dv_drop", data_valid, 0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_fill", fill_count, 0);

    // 64 back-to-back requests, then two idle cycles to drain.
    dv_cnt = 0; ld_cnt = 0; ld_at = -1;
    for (int j = 0; j < 66; j++) begin
      if (j < 64) req(j % 8, (j + 3) % 8, j / 8, j % 8);
      else read_en = 1'b0;
      step();
      if (data_valid) dv_cnt++;
      if (load_done) begin
        ld_cnt++;
        ld_at = j;
      end
    end
    check("b2b_dv_count", dv_cnt, 64);
    check("b2b_ld_pulses", ld_cnt, 1);
    check("b2b_ld_cycle", ld_at, 64);
    check("b2b_fill", fill_count, 64);
    look(7, 7);
    check("b2b_w77", weight_out, 32'h107);
    check("b2b_a77", act_out, 32'h202);
    look(3, 4);
    check("b2b_w34", weight_out, 32'h104);
    check("b2b_a34", act_out, 32'h207);

    // 65th request: saturated count, no second pulse.
    req(0, 0, 0, 0);
    ld_again = 0; dv_seen = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      read_en = 1'b0;
      if (load_done) ld_again++;
      if (data_valid) dv_seen++;
    end
    check("sat_no_repulse", ld_again, 0);
    check("sat_dv", dv_seen, 1);
    check("sat_fill", fill_count, 64);

    // Out-of-range bank 8: data returned, no write, sticky overrun.
    clear = 1'b1;
    step();
    clear = 1'b0;
    req(6, 6, 8, 1);
    step();
    read_en = 1'b0;
    step();
    check("ovr_dv", data_valid, 1);
    check("ovr_rom_data", rom_data, 32'h106);
    check("ovr_ram_data", ram_data, 32'h206);
    check("ovr_fill", fill_count, 0);
    check("ovr_flag", overrun, 1);
    look(0, 1);
    check("ovr_no_write_w", weight_out, 32'h101);
    check("ovr_no_write_a", act_out, 32'h204);
    step(); step();
    check("ovr_sticky", overrun, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Enable low for 3 cycles right after a request.
    req(2, 5, 1, 1);
    step();
    read_en = 1'b0;
    enable  = 1'b0;
    check("stall_dv_t1", data_valid, 0);
    for (int j = 0; j < 3; j++) begin
      step();
      check("stall_dv_hold", data_valid, 0);
    end
    enable = 1'b1;
    step();
    check("stall_dv_late", data_valid, 1);
    check("stall_rom_data", rom_data, 32'h102);
    check("stall_ram_data", ram_data, 32'h205);
    check("stall_fill", fill_count, 1);

    // Preload of addr 4 on the same edge as the stage-2 read of addr 4.
    req(4, 4, 5, 5);
    step();
    read_en   = 1'b0;
    init_we   = 1'b1;
    init_mem  = 1'b0;
    init_addr = 3'd4;
    init_data = 32'hAAAA;
    step();
    init_we = 1'b0;
    check("coll_old_rom", rom_data, 32'h104);
    check("coll_old_ram", ram_data, 32'h204);
    req(4, 4, 5, 6);
    step();
    read_en = 1'b0;
    step();
    check("coll_new_rom", rom_data, 32'hAAAA);
    look(5, 6);
    check("coll_new_bank", weight_out, 32'hAAAA);

    // Reset with two requests in flight.
    req(1, 1, 6, 0);
    step();
    req(2, 2, 6, 1);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    read_en = 1'b0;
    step();
    check("mrst_rom_data", rom_data, 0);
    check("mrst_ram_data", ram_data, 0);
    check("mrst_dv", data_valid, 0);
    check("mrst_fill", fill_count, 0);
    look(5, 5);
    check("mrst_bank", weight_out, 0);
    reset = 1'b0;
    dv_seen = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      if (data_valid) dv_seen++;
    end
    check("mrst_no_dv", dv_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
